// File: rtl/cpu_arb_pkg.sv
// Shared types and helpers for the CPU request-FIFO write-port arbiter.
package cpu_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam int CNT_W = 4;

  // Index that follows idx in round-robin order over nreq requesters.
  function automatic int rr_next(input int idx, input int nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cpu_rr_pick.sv
// Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ.
module cpu_rr_pick
  import cpu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [2*NREQ-1:0] rot;

  // Rotating a doubled copy puts rr_ptr at bit 0; scan downward so the lowest offset wins.
  always_comb begin
    rot   = {valid, valid} >> rr_ptr;
    found = |valid;
    idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (rot[off]) idx = ID_W'((int'(rr_ptr) + off) % NREQ);
    end
  end

endmodule

// File: rtl/cpu_fifo_arb.sv
// Burst-locking round-robin arbiter sharing one cpu_fifo write port among NREQ requesters.
//   state   | meaning
//   IDLE    | no lock; pick next requester from rr_ptr when any valid
//   LOCK    | grant_id owns the FIFO port until its last beat (or overlong burst)
module cpu_fifo_arb
  import cpu_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int SIZE      = 32,
  parameter int ID_W      = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*SIZE-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 fifo_wr_en,
  output logic [SIZE+ID_W-1:0] fifo_din,
  input  logic                 fifo_full,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 burst_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [SIZE-1:0]  data_arr [NREQ];
  logic             accept;
  logic             last_beat;
  logic             over_len;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*SIZE +: SIZE];
  end

  cpu_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign busy       = (state == ST_LOCK);
  assign accept     = busy & req_valid[grant_id] & ~fifo_full;
  assign fifo_wr_en = accept;
  assign fifo_din   = {grant_id, data_arr[grant_id]};
  assign last_beat  = req_last[grant_id];
  assign over_len   = (beat_cnt >= MAX_CNT);

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = ~fifo_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept) begin
            // An overlong burst is closed as though last had been seen.
            if (last_beat || over_len) begin
              if (!last_beat) burst_err <= 1'b1;
              rr_ptr   <= ID_W'(rr_next(int'(grant_id), NREQ));
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else if (beat_cnt != '1) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fifo_arb.sv
// Directed and randomized checks of cpu_fifo_arb against a transaction-level reference model.
module tb_cpu_fifo_arb;

  localparam int NREQ      = 2;
  localparam int SIZE      = 32;
  localparam int ID_W      = 1;
  localparam int MAX_BURST = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*SIZE-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_wr_en;
  logic [SIZE+ID_W-1:0] fifo_din;
  logic                 fifo_full;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 burst_err;

  logic [SIZE-1:0] d [NREQ];

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*SIZE +: SIZE] = d[i];
  end

  always #5 clk = ~clk;

  cpu_fifo_arb #(.NREQ(NREQ), .SIZE(SIZE), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), next round-robin start, beats taken, error flag.
  int m_owner, m_next, m_beats;
  bit m_err;

  logic                 o_wr;
  logic [SIZE+ID_W-1:0] o_din;
  logic [NREQ-1:0]      o_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_next = 0; m_beats = 0; m_err = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks, advances model, returns at next posedge+1.
  task automatic cycle();
    logic [NREQ-1:0]      e_ready;
    logic                 e_wr;
    logic [SIZE+ID_W-1:0] e_din;
    #2;
    e_ready = '0; e_wr = 1'b0; e_din = '0;
    if (m_owner >= 0) begin
      e_ready[m_owner] = !fifo_full;
      e_wr  = req_valid[m_owner] && !fifo_full;
      e_din = {ID_W'(m_owner), d[m_owner]};
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    chk("burst_err", 64'(burst_err), 64'(m_err));
    if (m_owner >= 0) chk("grant_id", 64'(grant_id), 64'(m_owner));
    if (e_wr) chk("fifo_din", 64'(fifo_din), 64'(e_din));
    o_wr  = fifo_wr_en;
    o_din = fifo_din;
    o_acc = e_ready & req_valid;
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int cand;
        cand = (m_next + k) % NREQ;
        if (m_owner < 0 && req_valid[cand]) begin
          m_owner = cand;
          m_beats = 0;
        end
      end
    end else if (e_wr) begin
      m_beats++;
      if (req_last[m_owner] || m_beats > MAX_BURST) begin
        if (!req_last[m_owner]) m_err = 1;
        m_next  = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_beats = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input logic v, input logic l, input logic [SIZE-1:0] val);
    req_valid[i] = v;
    req_last[i]  = l;
    d[i]         = val;
  endtask

  initial begin
    int nw;
    int rem [NREQ];
    rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) d[i] = '0;
    model_reset();
    #2;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_wr", 64'(fifo_wr_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(burst_err), 64'(0));
    chk("rst_gid", 64'(grant_id), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three-beat burst from requester 0.
    beat(0, 1, 0, 32'hA000_0000);
    cycle();
    chk("t1_idle_wr", 64'(o_wr), 64'(0));
    cycle();
    chk("t1_din0", 64'(o_din), {31'd0, 1'b0, 32'hA000_0000});
    beat(0, 1, 0, 32'hA000_0001);
    cycle();
    chk("t1_din1", 64'(o_din), {31'd0, 1'b0, 32'hA000_0001});
    beat(0, 1, 1, 32'hA000_0002);
    cycle();
    chk("t1_din2", 64'(o_din), {31'd0, 1'b0, 32'hA000_0002});
    beat(0, 0, 0, '0);
    cycle();
    chk("t1_back_idle", 64'(busy), 64'(0));

    // Both requesters continuously valid with single-beat bursts: grants alternate 1,0,1,0.
    beat(0, 1, 1, $urandom);
    beat(1, 1, 1, $urandom);
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (o_wr) begin
        chk("t2_alt_id", 64'(o_din[SIZE]), 64'((nw % 2 == 0) ? 1 : 0));
        nw++;
      end
      for (int i = 0; i < NREQ; i++) if (o_acc[i]) d[i] = $urandom;
    end
    chk("t2_nwrites", 64'(nw), 64'(4));
    beat(0, 0, 0, '0);
    beat(1, 0, 0, '0);
    cycle();

    // Backpressure mid-burst on requester 1.
    beat(1, 1, 0, 32'hB000_0000);
    cycle();
    cycle();
    chk("t3_din0", 64'(o_din), {31'd0, 1'b1, 32'hB000_0000});
    beat(1, 1, 0, 32'hB000_0001);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t3_full_ready", 64'(req_ready), 64'(0));
      #(-0);
      @(negedge clk);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    cycle();
    chk("t3_held_beat", 64'(o_din), {31'd0, 1'b1, 32'hB000_0001});
    chk("t3_held_wr", 64'(o_wr), 64'(1));
    beat(1, 1, 1, 32'hB000_0002);
    cycle();
    chk("t3_din2", 64'(o_din), {31'd0, 1'b1, 32'hB000_0002});
    beat(1, 0, 0, '0);
    cycle();

    // Overlong burst from requester 0.
    beat(0, 1, 0, 32'hE000_0000);
    cycle();
    for (int b = 0; b < 5; b++) begin
      cycle();
      chk("t4_beat", 64'(o_din), {31'd0, 1'b0, 32'hE000_0000 + 32'(b)});
      beat(0, 1, 0, 32'hE000_0000 + 32'(b + 1));
    end
    chk("t4_err_set", 64'(burst_err), 64'(1));
    chk("t4_idle", 64'(busy), 64'(0));
    beat(0, 0, 0, '0);
    for (int c = 0; c < 3; c++) cycle();
    chk("t4_err_sticky", 64'(burst_err), 64'(1));

    // Asynchronous reset mid-burst.
    beat(0, 1, 0, 32'hF000_0000);
    cycle();
    cycle();
    beat(0, 1, 0, 32'hF000_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 64'(req_ready), 64'(0));
    chk("t5_rst_wr", 64'(fifo_wr_en), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_err", 64'(burst_err), 64'(0));
    model_reset();
    @(posedge clk); #1;
    beat(0, 1, 1, 32'h6000_0000);
    beat(1, 1, 0, 32'h7000_0000);
    rst_n = 1'b1;
    cycle();
    chk("t5_restart_gid", 64'(grant_id), 64'(0));
    cycle();
    chk("t5_restart_din", 64'(o_din), {31'd0, 1'b0, 32'h6000_0000});
    beat(0, 0, 0, '0);

    // Requester 1 locked and stalls while requester 0 waits.
    cycle();
    cycle();
    chk("t6_din0", 64'(o_din), {31'd0, 1'b1, 32'h7000_0000});
    beat(1, 0, 0, '0);
    beat(0, 1, 1, 32'h6000_0001);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("t6_stall_wr", 64'(o_wr), 64'(0));
      chk("t6_stall_gid", 64'(grant_id), 64'(1));
    end
    beat(1, 1, 1, 32'h7000_0001);
    cycle();
    chk("t6_resume", 64'(o_din), {31'd0, 1'b1, 32'h7000_0001});
    beat(1, 0, 0, '0);
    cycle();
    chk("t6_next_gid", 64'(grant_id), 64'(0));
    cycle();
    chk("t6_r0_din", 64'(o_din), {31'd0, 1'b0, 32'h6000_0001});
    beat(0, 0, 0, '0);
    cycle();

    // Randomized traffic with backpressure and mid-burst gaps.
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      fifo_full = ($urandom % 4 == 0);
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (o_acc[i]) begin
          rem[i]--;
          if (rem[i] > 0 && $urandom % 4 != 0) beat(i, 1, rem[i] == 1, $urandom);
          else beat(i, 0, 0, '0);
        end else if (!req_valid[i]) begin
          if (rem[i] > 0) begin
            if ($urandom % 2 == 0) beat(i, 1, rem[i] == 1, $urandom);
          end else if ($urandom % 3 == 0) begin
            rem[i] = $urandom_range(1, 6);
            beat(i, 1, rem[i] == 1, $urandom);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
